// File: rtl/bsg_fifo_mc_pkg.sv
// Shared types and width helpers for the multi-channel 1R1W FIFO.
package bsg_fifo_mc_pkg;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t eUnlocked = 1'b0;
    localparam arb_state_t eLocked   = 1'b1;

    // Channel-id width; at least one bit so the port never collapses.
    function automatic int unsigned ch_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Occupancy width able to hold the value els (full).
    function automatic int unsigned cnt_width(input int unsigned els);
        return $clog2(els + 1);
    endfunction

endpackage

// File: rtl/bsg_fifo_mc_rr_arb.sv
// Rotating-priority read arbiter with a grant lock held until the consumer accepts.
module bsg_fifo_mc_rr_arb
    import bsg_fifo_mc_pkg::*;
#(
    parameter int unsigned channels_p = 2,
    localparam int unsigned ch_w = ch_width(channels_p)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [channels_p-1:0] nonempty,
    input  logic                  yumi,
    output logic                  v_c,
    output logic [ch_w-1:0]       grant_c
);

    arb_state_t      state_r, state_n;
    logic [ch_w-1:0] rr_r, rr_n;
    logic [ch_w-1:0] lock_r, lock_n;
    logic            hi_found;
    logic [ch_w-1:0] hi_idx, lo_idx;

    // First non-empty at or above rr_r wins; otherwise first non-empty below it.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = int'(channels_p) - 1; i >= 0; i--) begin
            if (nonempty[i]) begin
                if (i >= int'(rr_r)) begin
                    hi_found = 1'b1;
                    hi_idx   = ch_w'(i);
                end else begin
                    lo_idx = ch_w'(i);
                end
            end
        end
    end

    always_comb begin
        state_n = state_r;
        lock_n  = lock_r;
        rr_n    = rr_r;
        v_c     = 1'b0;
        grant_c = '0;
        case (state_r)
            eUnlocked: begin
                v_c     = |nonempty;
                grant_c = hi_found ? hi_idx : lo_idx;
                if (v_c && !yumi) begin
                    state_n = eLocked;
                    lock_n  = grant_c;
                end
            end
            eLocked: begin
                v_c     = 1'b1;
                grant_c = lock_r;
                if (yumi) begin
                    state_n = eUnlocked;
                end
            end
            default: state_n = eUnlocked;
        endcase
        if (v_c && yumi) begin
            rr_n = (grant_c == ch_w'(channels_p - 1)) ? '0 : grant_c + ch_w'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= eUnlocked;
            rr_r    <= '0;
            lock_r  <= '0;
        end else begin
            state_r <= state_n;
            rr_r    <= rr_n;
            lock_r  <= lock_n;
        end
    end

endmodule

// File: rtl/bsg_fifo_1r1w_multi_channel.sv
// Multi-channel 1R1W FIFO: per-channel circular queues, id-steered writes, locked round-robin reads.
// Define BSG_FIFO_MC_PROTOCOL_CHECK_EN to enable the sticky err_o protocol checker.
module bsg_fifo_1r1w_multi_channel
    import bsg_fifo_mc_pkg::*;
#(
    parameter int unsigned width_p            = 16,
    parameter int unsigned els_p              = 4,
    parameter int unsigned channels_p         = 2,
    parameter int unsigned ready_THEN_valid_p = 0
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,
    input  logic                                        v_i,
    input  logic [ch_width(channels_p)-1:0]             ch_i,
    input  logic [width_p-1:0]                          data_i,
    output logic [channels_p-1:0]                       ready_param_o,
    output logic                                        v_o,
    output logic [ch_width(channels_p)-1:0]             ch_o,
    output logic [width_p-1:0]                          data_o,
    input  logic                                        yumi_i,
    output logic [channels_p*cnt_width(els_p)-1:0]      count_o,
    output logic                                        err_o
);

    localparam int unsigned ch_w    = ch_width(channels_p);
    localparam int unsigned cnt_w   = cnt_width(els_p);
    localparam int unsigned ptr_w   = $clog2(els_p);
    localparam int unsigned ch_span = 1 << ch_w;

    logic [width_p-1:0]    head_c [channels_p];
    logic [channels_p-1:0] full_c, nonempty_c, enq_c, deq_c;
    logic [ch_span-1:0]    ch_legal_c;
    logic                  ch_ok_c, wr_ok_c, deq_any_c;
    logic                  ready_en_r;
    logic                  arb_v_c;
    logic [ch_w-1:0]       grant_c;

    // Ids that encode past the last channel are legal bit patterns but not real channels.
    always_comb begin
        ch_legal_c = '0;
        for (int i = 0; i < int'(ch_span); i++) begin
            ch_legal_c[i] = (i < int'(channels_p));
        end
    end

    assign ch_ok_c       = ch_legal_c[ch_i];
    assign ready_param_o = ready_en_r ? ~full_c : '0;
    assign wr_ok_c       = v_i & ch_ok_c &
                           ((ready_THEN_valid_p != 0) ? ~full_c[ch_i] : ready_param_o[ch_i]);
    assign deq_any_c     = arb_v_c & yumi_i;

    // Holds ready low during reset and until the first edge after release.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) ready_en_r <= 1'b0;
        else            ready_en_r <= 1'b1;
    end

    for (genvar c = 0; c < channels_p; c++) begin : g_ch
        logic [width_p-1:0] mem_r [els_p];
        logic [ptr_w-1:0]   wptr_r, rptr_r;
        logic [cnt_w-1:0]   count_r;

        assign enq_c[c]      = wr_ok_c & (ch_i == ch_w'(c));
        assign deq_c[c]      = deq_any_c & (grant_c == ch_w'(c));
        assign full_c[c]     = (count_r == cnt_w'(els_p));
        assign nonempty_c[c] = (count_r != '0);
        assign head_c[c]     = mem_r[rptr_r];
        assign count_o[c*cnt_w +: cnt_w] = count_r;

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                wptr_r  <= '0;
                rptr_r  <= '0;
                count_r <= '0;
            end else begin
                if (enq_c[c]) wptr_r <= wptr_r + ptr_w'(1);
                if (deq_c[c]) rptr_r <= rptr_r + ptr_w'(1);
                case ({enq_c[c], deq_c[c]})
                    2'b10:   count_r <= count_r + cnt_w'(1);
                    2'b01:   count_r <= count_r - cnt_w'(1);
                    default: count_r <= count_r;
                endcase
            end
        end

        // Payload storage needs no reset; occupancy gates visibility.
        always_ff @(posedge clk_i) begin
            if (enq_c[c]) mem_r[wptr_r] <= data_i;
        end
    end

    bsg_fifo_mc_rr_arb #(
        .channels_p(channels_p)
    ) u_arb (
        .clk      (clk_i),
        .rst_n    (reset_n_i),
        .nonempty (nonempty_c),
        .yumi     (yumi_i),
        .v_c      (arb_v_c),
        .grant_c  (grant_c)
    );

    assign v_o    = arb_v_c;
    assign ch_o   = grant_c;
    assign data_o = head_c[grant_c];

`ifdef BSG_FIFO_MC_PROTOCOL_CHECK_EN
    logic        err_r;
    logic        illegal_c;
    logic [31:0] cyc_r;

    assign illegal_c = (v_i & ~ch_ok_c) | (v_i & ch_ok_c & full_c[ch_i]) | (yumi_i & ~arb_v_c);
    assign err_o     = err_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_r <= 1'b0;
            cyc_r <= '0;
        end else begin
            cyc_r <= cyc_r + 32'd1;
            if (illegal_c) begin
                err_r <= 1'b1;
                $error("bsg_fifo_1r1w_multi_channel: illegal op at cycle %0d ch %0d", cyc_r, ch_i);
            end
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_multi_channel.sv
// Randomised and directed bench for bsg_fifo_1r1w_multi_channel against a queue-based model.
module tb_bsg_fifo_1r1w_multi_channel;

    localparam int W   = 16;
    localparam int ELS = 4;
    localparam int NCH = 2;
    localparam int NW  = 3;
`ifdef BSG_FIFO_MC_PROTOCOL_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk_i     = 1'b0;
    logic             reset_n_i = 1'b1;
    logic             v_i       = 1'b0;
    logic [0:0]       ch_i      = '0;
    logic [W-1:0]     data_i    = '0;
    logic             yumi_i    = 1'b0;
    logic [NCH-1:0]   ready_param_o;
    logic             v_o;
    logic [0:0]       ch_o;
    logic [W-1:0]     data_o;
    logic [NCH*NW-1:0] count_o;
    logic             err_o;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    int rr_d [4] = '{1, 9, 2, 8};
    int rr_c [4] = '{0, 1, 0, 1};

    bsg_fifo_1r1w_multi_channel dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .v_i           (v_i),
        .ch_i          (ch_i),
        .data_i        (data_i),
        .ready_param_o (ready_param_o),
        .v_o           (v_o),
        .ch_o          (ch_o),
        .data_o        (data_o),
        .yumi_i        (yumi_i),
        .count_o       (count_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: one queue per channel plus lock / round-robin bookkeeping.
    logic [W-1:0] q [NCH][$];
    bit locked_m   = 1'b0;
    int lch_m      = 0;
    int rr_m       = 0;
    bit ready_en_m = 1'b0;
    bit err_m      = 1'b0;

    function automatic void pres(output bit v, output int ch);
        int idx;
        v  = 1'b0;
        ch = 0;
        if (locked_m) begin
            v  = 1'b1;
            ch = lch_m;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                idx = (rr_m + k) % NCH;
                if (!v && q[idx].size() > 0) begin
                    v  = 1'b1;
                    ch = idx;
                end
            end
        end
    endfunction

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int c = 0; c < NCH; c++) q[c].delete();
            locked_m   = 1'b0;
            lch_m      = 0;
            rr_m       = 0;
            ready_en_m = 1'b0;
            err_m      = 1'b0;
        end else begin
            bit v;
            int ch;
            bit enq;
            int wc;
            pres(v, ch);
            wc  = int'(ch_i);
            enq = v_i && (wc < NCH) && ready_en_m && (q[wc].size() < ELS);
            if (ERR_EN && ((v_i && (wc >= NCH || q[wc].size() == ELS)) || (yumi_i && !v)))
                err_m = 1'b1;
            if (v && yumi_i) begin
                void'(q[ch].pop_front());
                rr_m = (ch + 1) % NCH;
            end
            if (!locked_m && v && !yumi_i) begin
                locked_m = 1'b1;
                lch_m    = ch;
            end else if (locked_m && yumi_i) begin
                locked_m = 1'b0;
            end
            if (enq) q[wc].push_back(data_i);
            ready_en_m = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_i) begin
        if (chk_on) begin
            bit v;
            int ch;
            logic [NCH*NW-1:0] ec;
            logic [NCH-1:0]    er;
            pres(v, ch);
            for (int c = 0; c < NCH; c++) begin
                ec[c*NW +: NW] = NW'(q[c].size());
                er[c]          = ready_en_m && (q[c].size() < ELS);
            end
            check("model_v_o", v_o, v);
            if (v) begin
                check("model_ch_o", ch_o, ch);
                check("model_data_o", data_o, q[ch][0]);
            end
            check("model_count_o", count_o, ec);
            check("model_ready", ready_param_o, er);
            check("model_err_o", err_o, err_m);
        end
    end

    task automatic step(input bit v, input bit ch, input logic [W-1:0] d, input bit y);
        v_i    = v;
        ch_i   = ch;
        data_i = d;
        yumi_i = y;
        @(posedge clk_i);
        #1;
        v_i    = 1'b0;
        yumi_i = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset_n_i = 1'b0;
        #1;
        check("async_rst_count", count_o, 0);
        check("async_rst_v", v_o, 0);
        @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        chk_on = 1'b1;
        #1 reset_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_count", count_o, 0);
        check("rst_ready", ready_param_o, 0);
        check("rst_v", v_o, 0);
        check("rst_ch", ch_o, 0);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("idle_ready", ready_param_o, 2'b11);
        check("idle_v", v_o, 0);
        check("idle_count", count_o, 0);
        check("idle_err", err_o, 0);

        // Fill channel 0, overflow write dropped, drain in order.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, W'(16'hA0 + i), 1'b0);
        check("fill_ready", ready_param_o, 2'b10);
        check("fill_count", count_o, 4);
        step(1'b1, 1'b0, 16'hA4, 1'b0);
        check("overflow_count", count_o, 4);
        for (int i = 0; i < 4; i++) begin
            check("drain_data", data_o, 16'hA0 + i);
            check("drain_ch", ch_o, 0);
            step(1'b0, 1'b0, '0, 1'b1);
        end
        check("drain_v", v_o, 0);
        check("drain_count", count_o, 0);

        // Round-robin alternation from a fresh rotation pointer.
        do_reset();
        step(1'b1, 1'b0, 16'd1, 1'b0);
        step(1'b1, 1'b0, 16'd2, 1'b0);
        step(1'b1, 1'b1, 16'd9, 1'b0);
        step(1'b1, 1'b1, 16'd8, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("rr_data", data_o, rr_d[i]);
            check("rr_ch", ch_o, rr_c[i]);
            step(1'b0, 1'b0, '0, 1'b1);
        end

        // Lock holds ch1 while ch0 becomes non-empty.
        step(1'b1, 1'b1, 16'h55, 1'b0);
        step(1'b1, 1'b0, 16'h66, 1'b0);
        check("lock_ch", ch_o, 1);
        check("lock_data", data_o, 16'h55);
        step(1'b0, 1'b0, '0, 1'b0);
        check("lock_ch_hold", ch_o, 1);
        check("lock_data_hold", data_o, 16'h55);
        step(1'b0, 1'b0, '0, 1'b1);
        check("unlock_ch", ch_o, 0);
        check("unlock_data", data_o, 16'h66);
        step(1'b0, 1'b0, '0, 1'b1);

        // Simultaneous enqueue/dequeue on ch0 across pointer wrap.
        step(1'b1, 1'b0, 16'h10, 1'b0);
        step(1'b1, 1'b0, 16'h11, 1'b0);
        check("sim_count_init", count_o, 2);
        for (int i = 0; i < 10; i++) begin
            check("sim_data", data_o, 16'h10 + i);
            check("sim_count", count_o, 2);
            step(1'b1, 1'b0, W'(16'h12 + i), 1'b1);
        end
        check("sim_tail0", data_o, 16'h1A);
        step(1'b0, 1'b0, '0, 1'b1);
        check("sim_tail1", data_o, 16'h1B);
        step(1'b0, 1'b0, '0, 1'b1);
        check("sim_empty", count_o, 0);

        // Yumi with nothing presented.
        step(1'b0, 1'b0, '0, 1'b1);
        check("err_set", err_o, ERR_EN);
        check("err_count", count_o, 0);
        step(1'b0, 1'b0, '0, 1'b0);
        check("err_sticky", err_o, ERR_EN);

        // Random traffic with a mid-run asynchronous reset.
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) do_reset();
            step(($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
                 W'($urandom), ($urandom_range(0, 99) < 40));
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
